// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decode results and detects load-use
// hazards. Bubbles are inserted on flush or stall and counted in a
// saturating counter.
module id_ex_stage_reg #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       id_ALUop,
    input  logic             id_branch,
    input  logic             id_memRead,
    input  logic             id_memtoReg,
    input  logic             id_memWrite,
    input  logic             id_ALUsrc,
    input  logic             id_regWrite,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       ex_ALUop,
    output logic             ex_branch,
    output logic             ex_memRead,
    output logic             ex_memtoReg,
    output logic             ex_memWrite,
    output logic             ex_ALUsrc,
    output logic             ex_regWrite,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rdata1,
    output logic [XLEN-1:0]  ex_rdata2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic [CNT_W-1:0] bubble_count
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic bubble;

    // Load-use hazard: EX holds a load whose destination the decode
    // instruction reads; masked while flushing or frozen.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_valid && ex_memRead && (ex_rd != 5'd0) && id_valid
                   && (rs1_hit || rs2_hit);
        stall    = load_use && !flush && !hold;
        bubble   = flush || stall;
    end

    // Pipeline register: flush/stall insert a bubble, hold freezes, else capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ALUop    <= 2'b00;
            ex_branch   <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memtoReg <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_ALUsrc   <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_pc       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 4'd0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_ALUop    <= 2'b00;
            ex_branch   <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memtoReg <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_ALUsrc   <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_pc       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 4'd0;
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_ALUop    <= id_valid ? id_ALUop : 2'b00;
            ex_branch   <= id_valid && id_branch;
            ex_memRead  <= id_valid && id_memRead;
            ex_memtoReg <= id_valid && id_memtoReg;
            ex_memWrite <= id_valid && id_memWrite;
            ex_ALUsrc   <= id_ALUsrc;
            ex_regWrite <= id_valid && id_regWrite;
            ex_pc       <= id_pc;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

    // Saturating count of inserted bubbles; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (bubble && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg (counter narrowed to 3 bits so
// saturation is reachable).
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [1:0]       id_ALUop;
    logic             id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUsrc, id_regWrite;
    logic [XLEN-1:0]  id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic [3:0]       id_funct;
    logic             flush, hold;
    logic             stall;
    logic             ex_valid;
    logic [1:0]       ex_ALUop;
    logic             ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUsrc, ex_regWrite;
    logic [XLEN-1:0]  ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_funct;
    logic [CNT_W-1:0] bubble_count;

    int total = 0;
    int bad   = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUop(id_ALUop),
        .id_branch(id_branch), .id_memRead(id_memRead), .id_memtoReg(id_memtoReg),
        .id_memWrite(id_memWrite), .id_ALUsrc(id_ALUsrc), .id_regWrite(id_regWrite),
        .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct(id_funct),
        .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .ex_ALUop(ex_ALUop), .ex_branch(ex_branch),
        .ex_memRead(ex_memRead), .ex_memtoReg(ex_memtoReg), .ex_memWrite(ex_memWrite),
        .ex_ALUsrc(ex_ALUsrc), .ex_regWrite(ex_regWrite),
        .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id;
        id_valid = 1'b0; id_ALUop = 2'b00; id_branch = 1'b0; id_memRead = 1'b0;
        id_memtoReg = 1'b0; id_memWrite = 1'b0; id_ALUsrc = 1'b0; id_regWrite = 1'b0;
        id_pc = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_funct = 4'd0;
    endtask

    task automatic load(input logic [4:0] rd);
        clr_id;
        id_valid = 1'b1; id_memRead = 1'b1; id_memtoReg = 1'b1; id_ALUsrc = 1'b1;
        id_regWrite = 1'b1; id_rs1 = 5'd2; id_use_rs1 = 1'b1; id_rd = rd; id_imm = 64'h8;
    endtask

    task automatic rtype(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        clr_id;
        id_valid = 1'b1; id_ALUop = 2'b10; id_regWrite = 1'b1;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        clr_id;
        #2;
        chk("rst_valid", 64'(ex_valid), 64'h0);
        chk("rst_cnt", 64'(bubble_count), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        #10 reset = 1'b0;
        tick;

        // R-type passthrough
        rtype(5'd1, 5'd2, 5'd7);
        id_rdata1 = 64'h11; id_rdata2 = 64'h22; id_pc = 64'h1000; id_funct = 4'h8;
        tick;
        chk("r_alu", 64'(ex_ALUop), 64'h2);
        chk("r_regw", 64'(ex_regWrite), 64'h1);
        chk("r_rd1", ex_rdata1, 64'h11);
        chk("r_rd2", ex_rdata2, 64'h22);
        chk("r_rd", 64'(ex_rd), 64'h7);
        chk("r_pc", ex_pc, 64'h1000);
        chk("r_funct", 64'(ex_funct), 64'h8);
        chk("r_stall", 64'(stall), 64'h0);

        // Load-use: load x5 then add reading x5 via rs2
        load(5'd5);
        tick;
        chk("ld_mr", 64'(ex_memRead), 64'h1);
        rtype(5'd6, 5'd5, 5'd9);
        id_rdata1 = 64'h100; id_rdata2 = 64'h200;
        #1;
        chk("lu_stall", 64'(stall), 64'h1);
        tick;
        chk("lu_bub_valid", 64'(ex_valid), 64'h0);
        chk("lu_bub_regw", 64'(ex_regWrite), 64'h0);
        chk("lu_bub_mr", 64'(ex_memRead), 64'h0);
        chk("lu_cnt", 64'(bubble_count), 64'h1);
        chk("lu_stall_off", 64'(stall), 64'h0);
        tick;
        chk("lu_add_valid", 64'(ex_valid), 64'h1);
        chk("lu_add_rd", 64'(ex_rd), 64'h9);
        chk("lu_add_rd2", ex_rdata2, 64'h200);
        chk("lu_cnt2", 64'(bubble_count), 64'h1);

        // Load to x0 never stalls
        load(5'd0);
        tick;
        rtype(5'd0, 5'd0, 5'd4);
        #1;
        chk("x0_stall", 64'(stall), 64'h0);

        // Matching rs1 that is not used does not stall
        load(5'd3);
        tick;
        rtype(5'd3, 5'd4, 5'd8);
        id_use_rs1 = 1'b0;
        #1;
        chk("unused_stall", 64'(stall), 64'h0);
        id_use_rs1 = 1'b1;
        #1;
        chk("used_stall", 64'(stall), 64'h1);

        // Flush together with hazard: one bubble, counter +1
        flush = 1'b1;
        #1;
        chk("fl_stall", 64'(stall), 64'h0);
        tick;
        flush = 1'b0;
        chk("fl_valid", 64'(ex_valid), 64'h0);
        chk("fl_cnt", 64'(bubble_count), 64'h2);

        // Hold with a pending hazard: frozen, stall masked, counter unchanged
        load(5'd10);
        tick;
        rtype(5'd10, 5'd11, 5'd12);
        hold = 1'b1;
        #1;
        chk("hold_stall", 64'(stall), 64'h0);
        for (int i = 0; i < 3; i++) begin
            id_rd = 5'(20 + i); id_rdata1 = 64'(i + 1);
            tick;
            chk("hold_rd", 64'(ex_rd), 64'ha);
            chk("hold_mr", 64'(ex_memRead), 64'h1);
            chk("hold_cnt", 64'(bubble_count), 64'h2);
        end
        hold = 1'b0;
        #1;
        chk("unhold_stall", 64'(stall), 64'h1);
        tick;
        chk("unhold_cnt", 64'(bubble_count), 64'h3);
        chk("unhold_valid", 64'(ex_valid), 64'h0);

        // id_valid=0 zeroes control but still captures data fields
        clr_id;
        id_ALUop = 2'b11; id_memRead = 1'b1; id_regWrite = 1'b1; id_branch = 1'b1;
        id_rd = 5'd13;
        tick;
        chk("inv_valid", 64'(ex_valid), 64'h0);
        chk("inv_alu", 64'(ex_ALUop), 64'h0);
        chk("inv_mr", 64'(ex_memRead), 64'h0);
        chk("inv_regw", 64'(ex_regWrite), 64'h0);
        chk("inv_br", 64'(ex_branch), 64'h0);
        chk("inv_rd", 64'(ex_rd), 64'hd);
        chk("inv_cnt", 64'(bubble_count), 64'h3);

        // Bring counter to 5 and capture regWrite=1, then async reset mid-cycle
        flush = 1'b1;
        tick;
        tick;
        flush = 1'b0;
        rtype(5'd1, 5'd2, 5'd15);
        tick;
        chk("pre_rst_cnt", 64'(bubble_count), 64'h5);
        chk("pre_rst_regw", 64'(ex_regWrite), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_regw", 64'(ex_regWrite), 64'h0);
        chk("arst_valid", 64'(ex_valid), 64'h0);
        chk("arst_rd", 64'(ex_rd), 64'h0);
        chk("arst_alu", 64'(ex_ALUop), 64'h0);
        chk("arst_cnt", 64'(bubble_count), 64'h0);
        #1 reset = 1'b0;
        rtype(5'd1, 5'd2, 5'd17);
        tick;
        chk("post_rst_rd", 64'(ex_rd), 64'h11);
        chk("post_rst_valid", 64'(ex_valid), 64'h1);

        // Saturation: ten flush bubbles on a 3-bit counter
        flush = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("sat_cnt", 64'(bubble_count), (k < 7) ? 64'(k) : 64'h7);
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the decode control unit.
- Captures decoded control signals (ALUop, branch, memRead, memtoReg, memWrite, ALUsrc, regWrite), operands, immediate and register indices each cycle.
- Performs load-use hazard detection, generating the stall for PC and IF/ID.
- Inserts bubbles on load-use stall or branch flush, and counts inserted bubbles.

Parameters:
- XLEN, 64, datapath width of PC, operands and immediate.
- CNT_W, 32, width of the saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  IF/ID holds a real instruction.
- id_ALUop  input  2  from control unit.
- id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUsrc, id_regWrite  input  1 each  from control unit.
- id_pc  input  XLEN  PC of the decode instruction.
- id_rdata1, id_rdata2  input  XLEN  register-file read data.
- id_imm  input  XLEN  generated immediate.
- id_rs1, id_rs2, id_rd  input  5 each  register indices.
- id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2.
- id_funct  input  4  {funct7[5], funct3} for the ALU control.
- flush  input  1  branch taken in EX; kill the decode instruction.
- hold  input  1  back-end freeze (memory wait); ID/EX keeps its contents.
- stall  output  1  combinational; freeze PC and IF/ID this cycle.
- ex_valid  output  1  registered.
- ex_ALUop  output  2  registered.
- ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUsrc, ex_regWrite  output  1 each  registered.
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  output  XLEN each  registered.
- ex_rs1, ex_rs2, ex_rd  output  5 each  registered.
- ex_funct  output  4  registered.
- bubble_count  output  CNT_W  registered, saturating.

Behaviour:
- Reset: asynchronous and active-high; all ex_* outputs and bubble_count go to 0 immediately, and the core stays there while reset is high. stall is then 0 because ex_memRead=0.
- Hazard detection (combinational):
  - stall = ex_valid & ex_memRead & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - stall is forced to 0 when flush=1 or hold=1.
- Per-edge update, priority highest first:
  1. flush: insert bubble.
  2. hold: keep all ex_* unchanged.
  3. stall: insert bubble.
  4. Otherwise capture all id_* into ex_*, with ex_valid=id_valid. If id_valid=0, the control outputs (ex_ALUop, branch, memRead, memtoReg, memWrite, regWrite) are zeroed regardless of id_* values.
- Bubble: ex_valid, ex_ALUop, ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUsrc and ex_regWrite go to 0. Data and index fields are don't-care; the implementation loads them with 0.
- The control unit does not drive memtoReg on stores or branches (value is stale). The register still captures it; downstream relies on regWrite=0 for those instructions.
- Latency: exactly 1 cycle from id_* to ex_* when not held. The registers have no combinational path; stall is the only combinational output.
- Load-use: one stall cycle per hazard. On the next edge ID/EX holds a bubble, so ex_memRead=0 and stall deasserts. The instruction re-decodes and is captured one cycle later.
- bubble_count: increments by 1 on each edge where a bubble is inserted (flush or stall path, not hold). It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Simultaneous flush and stall: flush wins, one bubble, counter +1 (not +2).
- Simultaneous hold and stall: stall is masked, contents held, counter unchanged.
- Reset asserted mid-operation: outputs clear asynchronously without waiting for clk. Capture resumes on the first rising edge after reset deasserts.

Test Plan:
- Reset check: assert reset asynchronously between edges with ex_regWrite=1 and bubble_count=5 -> all ex_* and bubble_count read 0 before the next clk edge.
- R-type passthrough: id_valid=1, ALUop=2'b10, regWrite=1, rdata1=0x11, rdata2=0x22, rd=7 -> one edge later ex_ALUop=2'b10, ex_regWrite=1, ex_rdata1=0x11, ex_rd=7, stall=0.
- Load-use: capture a load with rd=5 (memRead=1), then decode `add` with rs2=5, use_rs2=1 -> stall=1 for exactly one cycle, next ex_* is a bubble with bubble_count=1, and the add is captured the following edge.
- x0 and unused operand: load with rd=0 followed by a reader of x0 -> stall=0. Load with rd=3 followed by an instruction with rs1=3 but use_rs1=0 -> stall=0.
- Flush priority: flush=1 together with a load-use hazard -> stall=0, a single bubble, bubble_count +1. hold=1 for 3 cycles -> ex_* constant and counter unchanged.
- Saturation: with CNT_W=3, insert 10 consecutive flush bubbles -> bubble_count stops at 7.
